spi_flash_reader: RTL and testbench
===================================

Name: spi_flash_reader

Overview:
- Fabric-side SPI master that reads the configuration QSPI flash through the STARTUPE2 user-CCLK path (SCK drives USRCCLKO).
- Companion to the gold image's host pass-through: here the FPGA itself initiates single-lane READ (0x03) transactions.
- Read data is returned as a byte stream with a valid/ready handshake.
- Used by the gold image for header/CRC checks and multiboot decisions.

Parameters:
- G_CLK_DIV, 2: SCK half-period in p_in_clk cycles; legal range >=1.
- G_CS_HI, 4: minimum p_in_clk cycles cs_n is held high between transactions.
- G_LEN_W, 16: width of the byte-count input.
- G_INIT_CLKS, 3: dummy SCK pulses issued after reset with cs_n high, to absorb the STARTUPE2 lost first edges.

Ports:
- p_in_clk  in  1  system clock; all logic is on its rising edge
- p_in_rstn  in  1  asynchronous active-low reset
- p_in_start  in  1  one-cycle request; sampled only in IDLE
- p_in_addr  in  24  flash byte address, latched on accepted start
- p_in_len  in  G_LEN_W  bytes to read, latched on accepted start
- p_out_busy  out  1  high from reset or accepted start until return to IDLE
- p_out_done  out  1  one-cycle pulse at transaction end
- p_out_data  out  8  read byte, MSB first as received
- p_out_valid  out  1  p_out_data holds an unconsumed byte
- p_in_ready  in  1  consumer accepts the byte when valid&&ready
- p_out_spi_cs_n  out  1  flash chip select, active low
- p_out_spi_sck  out  1  to STARTUPE2 USRCCLKO
- p_out_spi_mosi  out  1  flash DQ0
- p_in_spi_miso  in  1  flash DQ1

Behaviour:
- Reset values: cs_n=1, sck=0, mosi=0, busy=1, done=0, valid=0, data=0. State machine enters INIT.
- SPI mode 0, SCK idle low:
  - A tick occurs every G_CLK_DIV cycles; each tick toggles SCK.
  - MISO is sampled on the rising edge.
  - MOSI is updated on the falling edge, MSB first.
- States:
  - INIT: G_INIT_CLKS full SCK pulses with cs_n=1, then IDLE.
  - IDLE: busy=0. When start=1 and len!=0: latch addr/len, cs_n=0 next cycle, mosi=0x03[7], go to SETUP. When start=1 and len=0: no SPI activity; done pulses on the next cycle.
  - SETUP: wait G_CLK_DIV cycles, then SHIFT.
  - SHIFT: 32 bits = {0x03, addr[23:0]}, then DATA.
  - DATA: 8*len bits. MOSI=0 throughout. The byte assembled after each 8th rising edge loads p_out_data and sets valid on the following cycle.
  - CS_HOLD: after the final falling edge, cs_n=1 for G_CS_HI cycles. Then done=1 for one cycle, busy=0, go to IDLE.
- Backpressure: at each byte boundary in DATA (SCK low, before the next rising edge), if valid=1 and ready=0, SCK freezes low and the divider holds. Resume when ready=1. Consumption in the same cycle as the boundary does not stall. No byte is ever overwritten or dropped.
- Valid clears on valid&&ready unless a new byte loads in the same cycle.
- The last byte may still be pending at done. done does not wait for consumption; valid stays high until ready.
- start while busy: ignored.
- Address wrap beyond 0xFFFFFF is left to the flash; the block does not track addresses.
- Async reset mid-transaction: cs_n immediately 1, pending byte discarded, INIT re-runs.

Decomposition:
- Package spi_flash_pkg holds:
  - C_CMD_READ = 8'h03
  - state enum {INIT, IDLE, SETUP, SHIFT, DATA, CS_HOLD}
  - C_ADDR_W = 24
- Sub-module spi_sck_gen: divider, tick generation, SCK toggle, freeze input. Reused later for a program/erase master.

Test Plan:
1. Reset release -> exactly 3 SCK pulses with cs_n=1, then busy=0. Check SCK period = 2*G_CLK_DIV cycles.
2. Flash model (byte = addr[7:0]+index), start addr=0x012340, len=4, ready=1:
   - MOSI carries 0x03,0x01,0x23,0x40.
   - Outputs 0x40,0x41,0x42,0x43.
   - done once; cs_n low for exactly 64 SCK cycles.
3. Same request with ready=0 for 50 cycles after byte 0 -> SCK frozen low, byte 0 held. On release, bytes 1..3 follow in order with no loss.
4. start with len=0 -> cs_n never falls; done pulses one cycle after start.
5. start reasserted while busy with addr=0xFFFFFF -> ignored; the original transfer's data and address are unchanged.
6. Assert p_in_rstn mid-DATA -> cs_n=1 and valid=0 asynchronously. INIT pulses repeat, then a new transaction completes correctly.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the fabric-side SPI flash masters.
package spi_flash_pkg;

  localparam logic [7:0]  C_CMD_READ = 8'h03;
  localparam int unsigned C_ADDR_W   = 24;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_DATA,
    ST_CS_HOLD
  } state_t;

  // Command header shifted out MSB first: opcode followed by byte address.
  typedef struct packed {
    logic [7:0]          cmd;
    logic [C_ADDR_W-1:0] addr;
  } spi_hdr_t;

  localparam int unsigned C_HDR_BITS = $bits(spi_hdr_t);

endpackage

// File: rtl/spi_sck_gen.sv
// SPI mode-0 SCK generator: toggles SCK every G_CLK_DIV cycles while enabled.
// Freeze holds both the divider and SCK; disabling parks SCK low.
module spi_sck_gen #(
  parameter int unsigned G_CLK_DIV = 2
) (
  input  logic p_in_clk,
  input  logic p_in_rstn,
  input  logic p_in_en,
  input  logic p_in_freeze,
  output logic p_out_sck,
  output logic p_out_rise_c,
  output logic p_out_fall_c
);

  localparam int unsigned C_DIV_W = (G_CLK_DIV > 1) ? $clog2(G_CLK_DIV) : 1;

  logic [C_DIV_W-1:0] r_div;
  logic               r_sck;
  logic               w_tick;

  assign w_tick = p_in_en && !p_in_freeze && (r_div == C_DIV_W'(G_CLK_DIV - 1));

  always_ff @(posedge p_in_clk or negedge p_in_rstn) begin
    if (!p_in_rstn) begin
      r_div <= '0;
      r_sck <= 1'b0;
    end else if (!p_in_en) begin
      r_div <= '0;
      r_sck <= 1'b0;
    end else if (!p_in_freeze) begin
      if (w_tick) begin
        r_div <= '0;
        r_sck <= ~r_sck;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  // Edge strobes mark the clk edge at which SCK changes level.
  assign p_out_sck    = r_sck;
  assign p_out_rise_c = w_tick && !r_sck;
  assign p_out_fall_c = w_tick && r_sck;

endmodule

// File: rtl/spi_flash_reader.sv
// Fabric SPI master issuing single-lane READ (0x03) to the config flash via
// STARTUPE2 USRCCLKO; read bytes are returned on a valid/ready stream.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int unsigned G_CLK_DIV   = 2,
  parameter int unsigned G_CS_HI     = 4,
  parameter int unsigned G_LEN_W     = 16,
  parameter int unsigned G_INIT_CLKS = 3
) (
  input  logic                p_in_clk,
  input  logic                p_in_rstn,
  input  logic                p_in_start,
  input  logic [C_ADDR_W-1:0] p_in_addr,
  input  logic [G_LEN_W-1:0]  p_in_len,
  output logic                p_out_busy,
  output logic                p_out_done,
  output logic [7:0]          p_out_data,
  output logic                p_out_valid,
  input  logic                p_in_ready,
  output logic                p_out_spi_cs_n,
  output logic                p_out_spi_sck,
  output logic                p_out_spi_mosi,
  input  logic                p_in_spi_miso
);

  localparam int unsigned C_CNT_W = 16;

  state_t               r_state;
  logic [C_CNT_W-1:0]   r_cnt;
  spi_hdr_t             r_tx;
  logic [G_LEN_W-1:0]   r_len_left;
  logic [2:0]           r_bit;
  logic [7:0]           r_rx;
  logic                 r_byte_rdy;
  logic [7:0]           r_data;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_cs_n;
  logic                 r_mosi;

  logic                 w_sck;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_sck_en;
  logic                 w_freeze;

  assign w_sck_en = ((r_state == ST_INIT) && (r_cnt != C_CNT_W'(G_INIT_CLKS))) ||
                    (r_state == ST_SETUP) || (r_state == ST_SHIFT) ||
                    (r_state == ST_DATA);

  // Byte boundary with an unconsumed byte: park SCK low until the consumer drains it.
  assign w_freeze = (r_state == ST_DATA) && !w_sck && (r_bit == 3'd0) &&
                    r_valid && !p_in_ready;

  spi_sck_gen #(
    .G_CLK_DIV (G_CLK_DIV)
  ) u_sck_gen (
    .p_in_clk     (p_in_clk),
    .p_in_rstn    (p_in_rstn),
    .p_in_en      (w_sck_en),
    .p_in_freeze  (w_freeze),
    .p_out_sck    (w_sck),
    .p_out_rise_c (w_rise),
    .p_out_fall_c (w_fall)
  );

  always_ff @(posedge p_in_clk or negedge p_in_rstn) begin
    if (!p_in_rstn) begin
      r_state    <= ST_INIT;
      r_cnt      <= '0;
      r_tx       <= '0;
      r_len_left <= '0;
      r_bit      <= '0;
      r_rx       <= '0;
      r_byte_rdy <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_byte_rdy <= 1'b0;

      // Output stream: a freshly assembled byte wins over a same-cycle consume.
      if (r_byte_rdy) begin
        r_data  <= r_rx;
        r_valid <= 1'b1;
      end else if (r_valid && p_in_ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_INIT: begin
          if (r_cnt == C_CNT_W'(G_INIT_CLKS)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (w_fall) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_IDLE: begin
          if (p_in_start) begin
            if (p_in_len != '0) begin
              r_tx       <= spi_hdr_t'{cmd: C_CMD_READ, addr: p_in_addr};
              r_len_left <= p_in_len;
              r_bit      <= '0;
              r_cnt      <= '0;
              r_cs_n     <= 1'b0;
              r_mosi     <= C_CMD_READ[7];
              r_busy     <= 1'b1;
              r_state    <= ST_SETUP;
            end else begin
              r_done <= 1'b1;
            end
          end
        end

        // The first rising edge ends the cs_n-to-SCK setup interval.
        ST_SETUP: begin
          if (w_rise) begin
            r_cnt   <= C_CNT_W'(1);
            r_state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (w_rise) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (w_fall) begin
            if (r_cnt == C_CNT_W'(C_HDR_BITS)) begin
              r_mosi  <= 1'b0;
              r_cnt   <= '0;
              r_state <= ST_DATA;
            end else begin
              r_mosi <= r_tx[C_HDR_BITS-2];
              r_tx   <= spi_hdr_t'({r_tx[C_HDR_BITS-2:0], 1'b0});
            end
          end
        end

        ST_DATA: begin
          if (w_rise) begin
            r_rx  <= {r_rx[6:0], p_in_spi_miso};
            r_bit <= r_bit + 1'b1;
            if (r_bit == 3'd7) begin
              r_byte_rdy <= 1'b1;
              r_len_left <= r_len_left - 1'b1;
            end
          end else if (w_fall && (r_bit == 3'd0) && (r_len_left == '0)) begin
            r_cs_n  <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_CS_HOLD;
          end
        end

        ST_CS_HOLD: begin
          if ((r_cnt + 1'b1) >= C_CNT_W'(G_CS_HI)) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
          r_cs_n  <= 1'b1;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign p_out_busy     = r_busy;
  assign p_out_done     = r_done;
  assign p_out_data     = r_data;
  assign p_out_valid    = r_valid;
  assign p_out_spi_cs_n = r_cs_n;
  assign p_out_spi_sck  = w_sck;
  assign p_out_spi_mosi = r_mosi;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: flash model (byte = addr[7:0] + index), stream
// scoreboard, vector table plus hand-written reset/backpressure sequences.
module tb_spi_flash_reader;

  localparam int unsigned G_CLK_DIV   = 2;
  localparam int unsigned G_CS_HI     = 4;
  localparam int unsigned G_LEN_W     = 16;
  localparam int unsigned G_INIT_CLKS = 3;

  logic               p_in_clk      = 1'b0;
  logic               p_in_rstn     = 1'b0;
  logic               p_in_start    = 1'b0;
  logic [23:0]        p_in_addr     = '0;
  logic [G_LEN_W-1:0] p_in_len      = '0;
  logic               p_in_ready    = 1'b1;
  logic               p_in_spi_miso = 1'b0;
  logic               p_out_busy;
  logic               p_out_done;
  logic [7:0]         p_out_data;
  logic               p_out_valid;
  logic               p_out_spi_cs_n;
  logic               p_out_spi_sck;
  logic               p_out_spi_mosi;

  spi_flash_reader #(
    .G_CLK_DIV   (G_CLK_DIV),
    .G_CS_HI     (G_CS_HI),
    .G_LEN_W     (G_LEN_W),
    .G_INIT_CLKS (G_INIT_CLKS)
  ) dut (
    .p_in_clk       (p_in_clk),
    .p_in_rstn      (p_in_rstn),
    .p_in_start     (p_in_start),
    .p_in_addr      (p_in_addr),
    .p_in_len       (p_in_len),
    .p_out_busy     (p_out_busy),
    .p_out_done     (p_out_done),
    .p_out_data     (p_out_data),
    .p_out_valid    (p_out_valid),
    .p_in_ready     (p_in_ready),
    .p_out_spi_cs_n (p_out_spi_cs_n),
    .p_out_spi_sck  (p_out_spi_sck),
    .p_out_spi_mosi (p_out_spi_mosi),
    .p_in_spi_miso  (p_in_spi_miso)
  );

  always #5 p_in_clk = ~p_in_clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          init_rises   = 0;
  int          init_period  = 0;
  longint      t_first      = 0;
  int          tx_rises     = 0;
  int          tx_falls     = 0;
  int          mosi_ones    = 0;
  int          cs_falls     = 0;
  int          done_cnt     = 0;
  logic [31:0] hdr          = '0;
  logic [7:0]  rx_q[$];
  bit          rnd_mode     = 1'b0;
  bit          ready_ctl    = 1'b1;

  typedef struct {
    logic [23:0] addr;
    int          len;
    int          stall;
    bit          restart;
    logic [7:0]  exp_first;
    int          exp_rises;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input longint act, input longint exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Consumer handshake driver.
  always @(posedge p_in_clk) begin
    #1;
    p_in_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : ready_ctl;
  end

  // Stream scoreboard capture and done counter.
  always @(negedge p_in_clk) begin
    if (p_out_valid && p_in_ready) rx_q.push_back(p_out_data);
    if (p_out_done) done_cnt++;
  end

  // Flash model: header capture on SCK rise, data driven on SCK fall.
  always @(negedge p_out_spi_cs_n) begin
    tx_rises  = 0;
    tx_falls  = 0;
    mosi_ones = 0;
    hdr       = '0;
    cs_falls++;
  end

  always @(posedge p_out_spi_sck) begin
    if (p_out_spi_cs_n) begin
      init_rises++;
      if (init_rises == 1) t_first = $time;
      else if (init_rises == 2) init_period = int'(($time - t_first) / 10);
    end else begin
      if (tx_rises < 32) hdr = {hdr[30:0], p_out_spi_mosi};
      else if (p_out_spi_mosi) mosi_ones++;
      tx_rises++;
    end
  end

  always @(negedge p_out_spi_sck) begin : flash_out
    int         j;
    logic [7:0] b;
    if (!p_out_spi_cs_n) begin
      tx_falls++;
      if (tx_falls >= 32) begin
        j = tx_falls - 32;
        b = hdr[7:0] + 8'(j / 8);
        p_in_spi_miso = b[7 - (j % 8)];
      end
    end
  end

  task automatic pulse_start(input logic [23:0] a, input int l);
    @(posedge p_in_clk);
    #1;
    p_in_start = 1'b1;
    p_in_addr  = a;
    p_in_len   = G_LEN_W'(l);
    @(posedge p_in_clk);
    #1;
    p_in_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int lim);
    int n = 0;
    while (p_out_busy && n < lim) begin
      @(negedge p_in_clk);
      n++;
    end
    chk(name, p_out_busy, 0);
  endtask

  task automatic run_txn(input logic [23:0] a, input int l, input int stall,
                         input bit restart, input logic [7:0] exp_first,
                         input int exp_rises);
    int n;
    int rises0;
    int got;
    rx_q.delete();
    done_cnt = 0;
    if (stall > 0) ready_ctl = 1'b0;
    pulse_start(a, l);
    if (restart) begin
      repeat (20) @(negedge p_in_clk);
      chk("busy_at_restart", p_out_busy, 1);
      pulse_start(24'hFFFFFF, 5);
    end
    if (stall > 0) begin
      n = 0;
      while (!p_out_valid && n < 3000) begin
        @(negedge p_in_clk);
        n++;
      end
      chk("stall_valid", p_out_valid, 1);
      rises0 = tx_rises;
      repeat (stall) @(negedge p_in_clk);
      chk("stall_sck_frozen", tx_rises, rises0);
      chk("stall_sck_low", p_out_spi_sck, 0);
      chk("stall_byte0_held", p_out_data, exp_first);
      chk("stall_valid_held", p_out_valid, 1);
      ready_ctl = 1'b1;
    end
    n = 0;
    while ((done_cnt == 0 || rx_q.size() < l) && n < 5000) begin
      @(negedge p_in_clk);
      n++;
    end
    repeat (10) @(negedge p_in_clk);
    chk("done_once", done_cnt, 1);
    chk("mosi_hdr", hdr, {8'h03, a});
    chk("mosi_zero_in_data", mosi_ones, 0);
    chk("sck_with_cs_low", tx_rises, exp_rises);
    chk("byte_count", rx_q.size(), l);
    chk("first_byte", (rx_q.size() > 0) ? int'(rx_q[0]) : -1, exp_first);
    for (int i = 0; i < l; i++) begin
      got = (i < rx_q.size()) ? int'(rx_q[i]) : -1;
      chk($sformatf("byte%0d", i), got, int'(8'(a[7:0] + 8'(i))));
    end
    chk("cs_idle_high", p_out_spi_cs_n, 1);
    chk("busy_idle_low", p_out_busy, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          n;
    int          c0;
    logic [23:0] a;
    int          l;

    vecs[0] = '{addr: 24'h012340, len: 4, stall: 0,  restart: 1'b0, exp_first: 8'h40, exp_rises: 64};
    vecs[1] = '{addr: 24'h012340, len: 4, stall: 50, restart: 1'b0, exp_first: 8'h40, exp_rises: 64};
    vecs[2] = '{addr: 24'h0000FE, len: 3, stall: 0,  restart: 1'b1, exp_first: 8'hFE, exp_rises: 56};
    vecs[3] = '{addr: 24'hFFFFFF, len: 2, stall: 0,  restart: 1'b0, exp_first: 8'hFF, exp_rises: 48};

    repeat (3) @(negedge p_in_clk);
    chk("rst_cs_n", p_out_spi_cs_n, 1);
    chk("rst_sck", p_out_spi_sck, 0);
    chk("rst_mosi", p_out_spi_mosi, 0);
    chk("rst_busy", p_out_busy, 1);
    chk("rst_done", p_out_done, 0);
    chk("rst_valid", p_out_valid, 0);
    chk("rst_data", p_out_data, 0);

    @(posedge p_in_clk);
    #1;
    p_in_rstn = 1'b1;
    wait_idle("init_to_idle", 500);
    chk("init_pulses", init_rises, 3);
    chk("init_sck_period", init_period, 2 * G_CLK_DIV);
    chk("init_cs_stays_high", cs_falls, 0);

    // Zero-length request: no chip select, done one cycle later.
    c0 = cs_falls;
    done_cnt = 0;
    pulse_start(24'h001000, 0);
    @(negedge p_in_clk);
    chk("len0_done_pulse", p_out_done, 1);
    @(negedge p_in_clk);
    chk("len0_done_single", p_out_done, 0);
    repeat (20) @(negedge p_in_clk);
    chk("len0_no_cs", cs_falls, c0);

    for (int v = 0; v < 4; v++)
      run_txn(vecs[v].addr, vecs[v].len, vecs[v].stall, vecs[v].restart,
              vecs[v].exp_first, vecs[v].exp_rises);

    rnd_mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      a = 24'($urandom);
      l = int'($urandom_range(1, 6));
      run_txn(a, l, 0, 1'b0, a[7:0], 32 + 8 * l);
    end
    rnd_mode  = 1'b0;
    ready_ctl = 1'b1;

    // Reset in the middle of DATA with a byte pending.
    rx_q.delete();
    pulse_start(24'h000010, 8);
    n = 0;
    while (rx_q.size() < 1 && n < 3000) begin
      @(negedge p_in_clk);
      n++;
    end
    ready_ctl = 1'b0;
    n = 0;
    while (!p_out_valid && n < 3000) begin
      @(negedge p_in_clk);
      n++;
    end
    chk("mid_valid_pending", p_out_valid, 1);
    chk("mid_cs_low", p_out_spi_cs_n, 0);
    #2;
    init_rises = 0;
    p_in_rstn  = 1'b0;
    #1;
    chk("mid_rst_cs_async", p_out_spi_cs_n, 1);
    chk("mid_rst_valid_async", p_out_valid, 0);
    chk("mid_rst_busy", p_out_busy, 1);
    repeat (2) @(negedge p_in_clk);
    @(posedge p_in_clk);
    #1;
    p_in_rstn = 1'b1;
    ready_ctl = 1'b1;
    wait_idle("reinit_to_idle", 500);
    chk("reinit_pulses", init_rises, 3);
    run_txn(24'h00ABCD, 3, 0, 1'b0, 8'hCD, 56);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
